// File: rtl/wb_pkg.sv
// Shared load-unit definitions: funct3 encodings, FSM state type and the
// access-size helper used by both the controller and the extractor.
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_t;

  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational merge of up to two memory beats, right-alignment of the
// addressed bytes and zero/sign extension to XLEN.
module load_align_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] beat0,
  input  logic [XLEN-1:0] beat1,
  input  logic [OFFW-1:0] off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   shifted;
  logic              sign_bit;
  logic              fill;
  int                nbits;

  assign merged  = {beat1, beat0};
  assign shifted = XLEN'(merged >> {off, 3'b000});

  // A full-width access keeps every bit, so the fill value never matters then.
  always_comb begin
    sign_bit = 1'b0;
    case (funct3[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    fill   = sign_bit & ~funct3[2];
    nbits  = 8 * int'(load_size(funct3));
    result = '0;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/wb_load_unit.sv
// Load/writeback unit: accepts one load, issues one or two aligned reads,
// and emits a registered one-cycle writeback pulse (or a fault).
module wb_load_unit
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault
);

  localparam int B    = XLEN / 8;
  localparam int OFFW = $clog2(B);

  state_t          state, state_next;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] ext_beat0, ext_beat1, ext_result;
  logic [XLEN-1:0] aligned_addr;
  logic            req_illegal, req_cross, cur_cross;

  function automatic logic is_cross(input logic [OFFW-1:0] off, input logic [2:0] f3);
    return (int'(off) + int'(load_size(f3))) > B;
  endfunction

  assign req_illegal = (req_funct3 == 3'b111) ||
                       ((XLEN == 32) && ((req_funct3 == LD) || (req_funct3 == LWU)));
  assign req_cross   = is_cross(req_addr[OFFW-1:0], req_funct3);
  assign cur_cross   = is_cross(addr_q[OFFW-1:0], funct3_q);

  assign aligned_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign req_ready     = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_ISSUE0) || (state == ST_ISSUE1);

  always_comb begin
    mem_req_addr = '0;
    if (state == ST_ISSUE0) mem_req_addr = aligned_addr;
    else if (state == ST_ISSUE1) mem_req_addr = aligned_addr + XLEN'(B);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (req_valid)
          state_next = (req_illegal || (req_cross && !MISALIGN_EN)) ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0: if (mem_req_ready) state_next = ST_WAIT0;
      ST_WAIT0:  if (mem_rsp_valid) state_next = cur_cross ? ST_ISSUE1 : ST_RESP;
      ST_ISSUE1: if (mem_req_ready) state_next = ST_WAIT1;
      ST_WAIT1:  if (mem_rsp_valid) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The beat arriving this cycle feeds the extractor directly so that the
  // writeback register loads on the same edge the FSM enters RESP.
  assign ext_beat0 = (state == ST_WAIT0) ? mem_rsp_data : beat0_q;
  assign ext_beat1 = (state == ST_WAIT1) ? mem_rsp_data : '0;

  load_align_extend #(.XLEN(XLEN)) u_align (
    .beat0  (ext_beat0),
    .beat1  (ext_beat1),
    .off    (addr_q[OFFW-1:0]),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      beat0_q  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_fault <= 1'b0;
    end else begin
      state    <= state_next;
      wb_valid <= (state_next == ST_RESP);
      wb_fault <= 1'b0;
      if (state == ST_IDLE && req_valid) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        rd_q     <= req_rd;
      end
      if (state == ST_WAIT0 && mem_rsp_valid) beat0_q <= mem_rsp_data;
      if (state == ST_IDLE && state_next == ST_RESP) begin
        wb_fault <= 1'b1;
        wb_data  <= '0;
        wb_rd    <= req_rd;
      end else if (state != ST_RESP && state_next == ST_RESP) begin
        wb_data <= ext_result;
        wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit: 32-bit split-capable, 32-bit fault-on-cross
// and 64-bit instances driven cycle by cycle with hand-computed results.
module tb_wb_load_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance a: XLEN=32, MISALIGN_EN=1
  logic        a_req_valid = 0, a_req_ready;
  logic [31:0] a_req_addr = 0;
  logic [2:0]  a_req_funct3 = 0;
  logic [4:0]  a_req_rd = 0;
  logic        a_mem_req_valid, a_mem_req_ready = 1;
  logic [31:0] a_mem_req_addr;
  logic        a_mem_rsp_valid = 0;
  logic [31:0] a_mem_rsp_data = 0;
  logic        a_wb_valid, a_wb_fault;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;

  // Instance b: XLEN=32, MISALIGN_EN=0
  logic        b_req_valid = 0, b_req_ready;
  logic [31:0] b_req_addr = 0;
  logic [2:0]  b_req_funct3 = 0;
  logic [4:0]  b_req_rd = 0;
  logic        b_mem_req_valid, b_mem_req_ready = 1;
  logic [31:0] b_mem_req_addr;
  logic        b_mem_rsp_valid = 0;
  logic [31:0] b_mem_rsp_data = 0;
  logic        b_wb_valid, b_wb_fault;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data;

  // Instance c: XLEN=64, MISALIGN_EN=1
  logic        c_req_valid = 0, c_req_ready;
  logic [63:0] c_req_addr = 0;
  logic [2:0]  c_req_funct3 = 0;
  logic [4:0]  c_req_rd = 0;
  logic        c_mem_req_valid, c_mem_req_ready = 1;
  logic [63:0] c_mem_req_addr;
  logic        c_mem_rsp_valid = 0;
  logic [63:0] c_mem_rsp_data = 0;
  logic        c_wb_valid, c_wb_fault;
  logic [4:0]  c_wb_rd;
  logic [63:0] c_wb_data;

  wb_load_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_funct3(a_req_funct3), .req_rd(a_req_rd),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_req_addr(a_mem_req_addr), .mem_rsp_valid(a_mem_rsp_valid),
    .mem_rsp_data(a_mem_rsp_data),
    .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .wb_fault(a_wb_fault)
  );

  wb_load_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_funct3(b_req_funct3), .req_rd(b_req_rd),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_req_addr(b_mem_req_addr), .mem_rsp_valid(b_mem_rsp_valid),
    .mem_rsp_data(b_mem_rsp_data),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .wb_fault(b_wb_fault)
  );

  wb_load_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) u_c (
    .clk(clk), .rst(rst),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
    .req_funct3(c_req_funct3), .req_rd(c_req_rd),
    .mem_req_valid(c_mem_req_valid), .mem_req_ready(c_mem_req_ready),
    .mem_req_addr(c_mem_req_addr), .mem_rsp_valid(c_mem_rsp_valid),
    .mem_rsp_data(c_mem_rsp_data),
    .wb_valid(c_wb_valid), .wb_rd(c_wb_rd), .wb_data(c_wb_data), .wb_fault(c_wb_fault)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request for one cycle on instance a; returns in cycle 1.
  task automatic apply_stimulus_a(input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [4:0] rd);
    a_req_addr = addr; a_req_funct3 = f3; a_req_rd = rd; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic apply_stimulus_c(input logic [63:0] addr, input logic [2:0] f3,
                                  input logic [4:0] rd);
    c_req_addr = addr; c_req_funct3 = f3; c_req_rd = rd; c_req_valid = 1'b1;
    tick();
    c_req_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();

    check_output("reset_req_ready", a_req_ready, 1);
    check_output("reset_mem_req_valid", a_mem_req_valid, 0);
    check_output("reset_mem_req_addr", a_mem_req_addr, 0);
    check_output("reset_wb", {a_wb_valid, a_wb_fault, a_wb_rd, a_wb_data}, 0);

    // LB at 0x103, byte 0x80 sign-extends
    apply_stimulus_a(32'h0000_0103, 3'b000, 5'd5);
    check_output("lb_c1_mem_valid", a_mem_req_valid, 1);
    check_output("lb_c1_mem_addr", a_mem_req_addr, 64'h100);
    check_output("lb_c1_req_ready", a_req_ready, 0);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'h8011_2233;
    check_output("lb_c2_mem_valid", a_mem_req_valid, 0);
    check_output("lb_c2_wb_valid", a_wb_valid, 0);
    tick();
    a_mem_rsp_valid = 0;
    check_output("lb_c3_wb_valid", a_wb_valid, 1);
    check_output("lb_c3_wb_data", a_wb_data, 64'hFFFF_FF80);
    check_output("lb_c3_wb_rd", a_wb_rd, 5);
    check_output("lb_c3_wb_fault", a_wb_fault, 0);
    tick();
    check_output("lb_c4_wb_valid", a_wb_valid, 0);
    check_output("lb_c4_req_ready", a_req_ready, 1);

    // LHU at 0x203 crosses into 0x204
    apply_stimulus_a(32'h0000_0203, 3'b101, 5'd7);
    check_output("lhu_c1_addr", a_mem_req_addr, 64'h200);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'hAABB_CCDD;
    tick();
    a_mem_rsp_valid = 0;
    check_output("lhu_c3_mem_valid", a_mem_req_valid, 1);
    check_output("lhu_c3_addr", a_mem_req_addr, 64'h204);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'h1122_3344;
    check_output("lhu_c4_wb_valid", a_wb_valid, 0);
    tick();
    a_mem_rsp_valid = 0;
    check_output("lhu_c5_wb_valid", a_wb_valid, 1);
    check_output("lhu_c5_wb_data", a_wb_data, 64'h0000_44AA);
    check_output("lhu_c5_wb_rd", a_wb_rd, 7);
    tick();

    // LH at 0xFFFFFFFF: second beat wraps to address 0
    apply_stimulus_a(32'hFFFF_FFFF, 3'b001, 5'd9);
    check_output("wrap_c1_addr", a_mem_req_addr, 64'hFFFF_FFFC);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'h1234_5678;
    tick();
    a_mem_rsp_valid = 0;
    check_output("wrap_c3_addr", a_mem_req_addr, 64'h0);
    check_output("wrap_c3_mem_valid", a_mem_req_valid, 1);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'h9ABC_DEF0;
    tick();
    a_mem_rsp_valid = 0;
    check_output("wrap_c5_wb_valid", a_wb_valid, 1);
    check_output("wrap_c5_wb_data", a_wb_data, 64'hFFFF_F012);
    tick();

    // Illegal funct3 011 on XLEN=32 faults without a memory request
    apply_stimulus_a(32'h0000_0400, 3'b011, 5'd3);
    check_output("ld32_c1_mem_valid", a_mem_req_valid, 0);
    check_output("ld32_c1_wb", {a_wb_valid, a_wb_fault, a_wb_rd}, {1'b1, 1'b1, 5'd3});
    check_output("ld32_c1_wb_data", a_wb_data, 0);
    tick();

    // Fault-on-cross instance: LW at 0x302
    b_req_addr = 32'h0000_0302; b_req_funct3 = 3'b010; b_req_rd = 5'd11; b_req_valid = 1;
    tick();
    b_req_valid = 0;
    check_output("nomis_c1_mem_valid", b_mem_req_valid, 0);
    check_output("nomis_c1_wb_valid", b_wb_valid, 1);
    check_output("nomis_c1_wb_fault", b_wb_fault, 1);
    check_output("nomis_c1_wb_data", b_wb_data, 0);
    check_output("nomis_c1_wb_rd", b_wb_rd, 11);
    tick();
    check_output("nomis_c2_wb_valid", b_wb_valid, 0);
    check_output("nomis_c2_mem_valid", b_mem_req_valid, 0);

    // Back-pressure: mem_req_ready low for three cycles
    a_mem_req_ready = 0;
    apply_stimulus_a(32'h0000_0400, 3'b010, 5'd12);
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("stall_c%0d_valid", i + 1), a_mem_req_valid, 1);
      check_output($sformatf("stall_c%0d_addr", i + 1), a_mem_req_addr, 64'h400);
      tick();
    end
    a_mem_req_ready = 1;
    check_output("stall_c4_valid", a_mem_req_valid, 1);
    check_output("stall_c4_addr", a_mem_req_addr, 64'h400);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'hDEAD_BEEF;
    check_output("stall_c5_wb_valid", a_wb_valid, 0);
    tick();
    a_mem_rsp_valid = 0;
    check_output("stall_c6_wb_valid", a_wb_valid, 1);
    check_output("stall_c6_wb_data", a_wb_data, 64'hDEAD_BEEF);
    tick();

    // Reset in WAIT0 aborts the load
    apply_stimulus_a(32'h0000_0010, 3'b000, 5'd4);
    tick();
    rst = 1;
    #1;
    check_output("rst_async_req_ready", a_req_ready, 1);
    check_output("rst_async_mem", {a_mem_req_valid, a_mem_req_addr}, 0);
    check_output("rst_async_wb", {a_wb_valid, a_wb_fault, a_wb_rd, a_wb_data}, 0);
    tick();
    rst = 0;
    tick();
    check_output("rst_after_wb_valid", a_wb_valid, 0);
    check_output("rst_after_req_ready", a_req_ready, 1);

    // Next request after reset: LH at 0x12
    apply_stimulus_a(32'h0000_0012, 3'b001, 5'd6);
    check_output("post_rst_addr", a_mem_req_addr, 64'h10);
    tick();
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'h8001_0000;
    tick();
    a_mem_rsp_valid = 0;
    check_output("post_rst_wb_valid", a_wb_valid, 1);
    check_output("post_rst_wb_data", a_wb_data, 64'hFFFF_8001);
    tick();

    // XLEN=64: LWU at 0x1004
    apply_stimulus_c(64'h1004, 3'b110, 5'd20);
    check_output("lwu64_c1_addr", c_mem_req_addr, 64'h1000);
    tick();
    c_mem_rsp_valid = 1; c_mem_rsp_data = 64'h89AB_CDEF_0123_4567;
    tick();
    c_mem_rsp_valid = 0;
    check_output("lwu64_c3_wb_valid", c_wb_valid, 1);
    check_output("lwu64_c3_wb_data", c_wb_data, 64'h0000_0000_89AB_CDEF);
    check_output("lwu64_c3_wb_rd", c_wb_rd, 20);
    tick();

    // XLEN=64: LD at 0x1000 returns the full word
    apply_stimulus_c(64'h1000, 3'b011, 5'd21);
    tick();
    c_mem_rsp_valid = 1; c_mem_rsp_data = 64'h89AB_CDEF_0123_4567;
    tick();
    c_mem_rsp_valid = 0;
    check_output("ld64_wb_data", c_wb_data, 64'h89AB_CDEF_0123_4567);
    check_output("ld64_wb_fault", c_wb_fault, 0);
    tick();

    // XLEN=64: funct3=111 at 0x1004 faults
    apply_stimulus_c(64'h1004, 3'b111, 5'd22);
    check_output("f111_c1_mem_valid", c_mem_req_valid, 0);
    check_output("f111_c1_wb", {c_wb_valid, c_wb_fault, c_wb_rd}, {1'b1, 1'b1, 5'd22});
    check_output("f111_c1_wb_data", c_wb_data, 0);
    tick();
    check_output("f111_c2_wb_valid", c_wb_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
